pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline (decode, readreg, execute, memwrt, regwrt).
- Per cycle it decides four things: whether S1 latches a new instruction (update), which stages get a bubble or flush (rst_p[4:1]), where each S2 operand comes from (forwarding selects), and when fetch is redirected by a delayed branch.
- Contains the load-use stall logic, a branch-flush counter and a HALT drain FSM.

Parameters:
- FLUSH_CYCLES, 3, number of cycles S1..S3 are flushed after a taken delayed branch (1..7).
- HALT_TYPE, 6'b111111, inst_type code of the HALT instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- num_Rm_1out  in  3  Rm number of the instruction entering S2.
- num_Rn_1out  in  3  Rn number of the instruction entering S2.
- num_Rd_1out  in  3  Rd number of the instruction entering S2.
- used_RmRnRd_1out  in  3  operand-used flags: [2]=Rm, [1]=Rn, [0]=Rd.
- inst_type_1out_2in  in  6  type of the instruction entering S2.
- writenum_2out, writenum_3out, writenum_out  in  3 each  destination registers at S2-out, S3-out and writeback.
- write_2out, write_3out, write_out  in  1 each  register-write enables at the same three points.
- loads_2out  in  1  the S2-out instruction is a load.
- do_delayed_B_4out  in  1  taken delayed branch at S4 (one-cycle pulse).
- update_1in  out  1  S1 latches a new instruction.
- rst_p  out  4  per-stage bubble/flush: [1]=S1 … [4]=S4.
- fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel  out  2 each  operand source select.
- pc_load  out  1  fetch must load delayed_B_4out this cycle.
- halted  out  1  the pipeline has drained after HALT.

Behaviour:
- Select encoding: 00 = regfile, 01 = result_2out_3in, 10 = S3 data (result_3out_4in; rdata_mem if the S3 instruction was a load), 11 = writeback_data_out.
- Forwarding (combinational, every state), evaluated per operand X in {Rm, Rn, Rd}:
  - sel = 01 if used_X && write_2out && writenum_2out==num_X;
  - else 10 if used_X && write_3out && writenum_3out==num_X;
  - else 11 if used_X && write_out && writenum_out==num_X;
  - else 00.
  - The youngest producer wins. R0 receives no special treatment.
- Load-use hazard: luh = loads_2out && write_2out && any used operand matches writenum_2out.
- FSM states RUN, FLUSH, HALT_DRAIN, HALTED.
- Reset (rst=1 at clk edge): state=RUN, flush counter=0, drain counter=0.
  - Outputs after reset: update_1in=1, rst_p=4'b0000, all sel=00, pc_load=0, halted=0.
- RUN:
  - default: update_1in=1, rst_p=0.
  - do_delayed_B_4out=1 (highest priority): pc_load=1, rst_p=4'b0111, counter loads FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES==1, return to RUN instead.
  - else if luh: update_1in=0 (S1 holds) and rst_p[2]=1 (bubble into S2); stay in RUN. This costs exactly one stall cycle per load-use; the next cycle the producer is at S3 and sel=10 resolves it.
  - else if inst_type_1out_2in==HALT_TYPE: update_1in=0, rst_p[1]=1, drain counter=3, go to HALT_DRAIN.
- FLUSH: rst_p=4'b0111, update_1in=1, pc_load=0.
  - The counter decrements each cycle; go to RUN in the cycle after the counter reads 0.
  - A further do_delayed_B_4out in FLUSH is ignored (S4 contents were already committed).
  - The luh stall is not evaluated in FLUSH.
- HALT_DRAIN: update_1in=0, rst_p[1]=1.
  - The drain counter decrements; at 0 go to HALTED.
  - do_delayed_B_4out here still asserts pc_load and rst_p[3:1] for one cycle, then the drain continues.
- HALTED: update_1in=0, rst_p=4'b1111, halted=1. Leaves only on rst.
- Reset mid-operation: any state returns to RUN next cycle with counters cleared and no pending flush.
- Simultaneous luh and branch: the branch wins, and luh is discarded because the consumer is flushed.

Test Plan:
- Reset held 2 cycles, then released → update_1in=1, rst_p=0000, sel=00, halted=0 on the first cycle after release.
- ADD writes R3, next instruction reads R3 as Rm (write_2out=1, writenum_2out=3, num_Rm_1out=3, used=100) → fwd_Rm_sel=01, no stall. With writenum_2out=4 and writenum_3out=3 instead → fwd_Rm_sel=10.
- LDR R2 at S2-out (loads_2out=1), consumer reads R2 as Rn → exactly one cycle of update_1in=0 with rst_p=0010. Next cycle fwd_Rn_sel=10 and update_1in=1.
- do_delayed_B_4out pulse with FLUSH_CYCLES=3 → pc_load=1 for 1 cycle, rst_p=0111 for 3 consecutive cycles, then RUN with rst_p=0000.
- Load-use and branch pulse in the same cycle → pc_load=1, rst_p=0111 (not 0010), state=FLUSH.
- inst_type_1out_2in=6'b111111 → update_1in=0 from that cycle, halted=1 four cycles later, rst_p=1111. rst during HALTED → RUN with halted=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: operand forwarding, load-use stall,
// delayed-branch flush and HALT drain.
module pipeline_hazard_ctrl #(
   parameter int          FLUSH_CYCLES = 3,
   parameter logic [5:0]  HALT_TYPE    = 6'b111111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] num_Rm_1out,
   input  logic [2:0] num_Rn_1out,
   input  logic [2:0] num_Rd_1out,
   input  logic [2:0] used_RmRnRd_1out,
   input  logic [5:0] inst_type_1out_2in,
   input  logic [2:0] writenum_2out,
   input  logic [2:0] writenum_3out,
   input  logic [2:0] writenum_out,
   input  logic       write_2out,
   input  logic       write_3out,
   input  logic       write_out,
   input  logic       loads_2out,
   input  logic       do_delayed_B_4out,
   output logic       update_1in,
   output logic [3:0] rst_p,
   output logic [1:0] fwd_Rm_sel,
   output logic [1:0] fwd_Rn_sel,
   output logic [1:0] fwd_Rd_sel,
   output logic       pc_load,
   output logic       halted
);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT_DRAIN, ST_HALTED} state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_flush_cnt;
   logic [2:0] w_flush_cnt_next;
   logic [1:0] r_drain_cnt;
   logic [1:0] w_drain_cnt_next;

   logic [2:0] w_num [3];
   logic [1:0] w_sel [3];
   logic [2:0] w_match2;
   logic       w_luh;

   // Index order follows used_RmRnRd_1out: 2=Rm, 1=Rn, 0=Rd.
   assign w_num[2] = num_Rm_1out;
   assign w_num[1] = num_Rn_1out;
   assign w_num[0] = num_Rd_1out;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_fwd
         assign w_match2[gi] = used_RmRnRd_1out[gi] && (writenum_2out == w_num[gi]);
         assign w_sel[gi] =
            (w_match2[gi] && write_2out)                                           ? 2'b01 :
            (used_RmRnRd_1out[gi] && write_3out && (writenum_3out == w_num[gi]))   ? 2'b10 :
            (used_RmRnRd_1out[gi] && write_out  && (writenum_out  == w_num[gi]))   ? 2'b11 :
                                                                                     2'b00;
      end
   endgenerate

   assign fwd_Rm_sel = w_sel[2];
   assign fwd_Rn_sel = w_sel[1];
   assign fwd_Rd_sel = w_sel[0];

   assign w_luh = loads_2out && write_2out && (|w_match2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_flush_cnt <= w_flush_cnt_next;
         r_drain_cnt <= w_drain_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      w_drain_cnt_next = r_drain_cnt;
      update_1in       = 1'b1;
      rst_p            = 4'b0000;
      pc_load          = 1'b0;
      halted           = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (do_delayed_B_4out) begin
               // The branch cycle itself is the first flushed cycle.
               pc_load          = 1'b1;
               rst_p            = 4'b0111;
               w_flush_cnt_next = FLUSH_LOAD;
               w_state_next     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
            end else if (w_luh) begin
               update_1in = 1'b0;
               rst_p      = 4'b0010;
            end else if (inst_type_1out_2in == HALT_TYPE) begin
               update_1in       = 1'b0;
               rst_p            = 4'b0001;
               w_drain_cnt_next = 2'd3;
               w_state_next     = ST_HALT_DRAIN;
            end
         end

         ST_FLUSH: begin
            rst_p = 4'b0111;
            if (r_flush_cnt <= 3'd1) begin
               w_flush_cnt_next = '0;
               w_state_next     = ST_RUN;
            end else begin
               w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
         end

         ST_HALT_DRAIN: begin
            update_1in = 1'b0;
            rst_p      = 4'b0001;
            if (do_delayed_B_4out) begin
               pc_load = 1'b1;
               rst_p   = 4'b0111;
            end
            if (r_drain_cnt <= 2'd1) begin
               w_drain_cnt_next = '0;
               w_state_next     = ST_HALTED;
            end else begin
               w_drain_cnt_next = r_drain_cnt - 2'd1;
            end
         end

         ST_HALTED: begin
            update_1in = 1'b0;
            rst_p      = 4'b1111;
            halted     = 1'b1;
         end

         default: w_state_next = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl, checked every cycle against a model that
// tracks flush/drain windows as absolute cycle numbers.
module tb_pipeline_hazard_ctrl;

   localparam int         FC = 3;
   localparam logic [5:0] HT = 6'b111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] num_Rm_1out, num_Rn_1out, num_Rd_1out, used_RmRnRd_1out;
   logic [5:0] inst_type_1out_2in;
   logic [2:0] writenum_2out, writenum_3out, writenum_out;
   logic       write_2out, write_3out, write_out, loads_2out, do_delayed_B_4out;
   logic       update_1in, pc_load, halted;
   logic [3:0] rst_p;
   logic [1:0] fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .HALT_TYPE(HT)) dut (
      .clk(clk), .rst(rst),
      .num_Rm_1out(num_Rm_1out), .num_Rn_1out(num_Rn_1out), .num_Rd_1out(num_Rd_1out),
      .used_RmRnRd_1out(used_RmRnRd_1out), .inst_type_1out_2in(inst_type_1out_2in),
      .writenum_2out(writenum_2out), .writenum_3out(writenum_3out), .writenum_out(writenum_out),
      .write_2out(write_2out), .write_3out(write_3out), .write_out(write_out),
      .loads_2out(loads_2out), .do_delayed_B_4out(do_delayed_B_4out),
      .update_1in(update_1in), .rst_p(rst_p),
      .fwd_Rm_sel(fwd_Rm_sel), .fwd_Rn_sel(fwd_Rn_sel), .fwd_Rd_sel(fwd_Rd_sel),
      .pc_load(pc_load), .halted(halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: cycle index, end of the flush window, cycle at which halted rises.
   int cyc          = 0;
   int flush_end    = 0;
   int halt_done    = 0;
   bit halt_pending = 1'b0;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [1:0] fwd_model(input bit used, input logic [2:0] num);
      if (used && write_2out && writenum_2out == num) return 2'b01;
      if (used && write_3out && writenum_3out == num) return 2'b10;
      if (used && write_out  && writenum_out  == num) return 2'b11;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      num_Rm_1out = 0; num_Rn_1out = 0; num_Rd_1out = 0; used_RmRnRd_1out = 0;
      inst_type_1out_2in = 0; writenum_2out = 0; writenum_3out = 0; writenum_out = 0;
      write_2out = 0; write_3out = 0; write_out = 0; loads_2out = 0; do_delayed_B_4out = 0;
   endtask

   task automatic cycle(input string tag, input bit chk);
      bit         luh, in_flush, draining, is_halted, new_flush, new_halt;
      bit         e_upd, e_pc, e_halt;
      logic [3:0] e_rst;
      logic [5:0] e_fwd;
      @(negedge clk);
      luh = loads_2out && write_2out &&
            ((used_RmRnRd_1out[2] && num_Rm_1out == writenum_2out) ||
             (used_RmRnRd_1out[1] && num_Rn_1out == writenum_2out) ||
             (used_RmRnRd_1out[0] && num_Rd_1out == writenum_2out));
      in_flush  = cyc < flush_end;
      draining  = halt_pending && cyc < halt_done;
      is_halted = halt_pending && cyc >= halt_done;
      new_flush = 0; new_halt = 0;
      e_upd = 1; e_rst = 4'b0000; e_pc = 0; e_halt = 0;
      if (is_halted) begin
         e_upd = 0; e_rst = 4'b1111; e_halt = 1;
      end else if (draining) begin
         e_upd = 0; e_rst = 4'b0001;
         if (do_delayed_B_4out) begin e_pc = 1; e_rst = 4'b0111; end
      end else if (in_flush) begin
         e_rst = 4'b0111;
      end else if (do_delayed_B_4out) begin
         e_pc = 1; e_rst = 4'b0111; new_flush = 1;
      end else if (luh) begin
         e_upd = 0; e_rst = 4'b0010;
      end else if (inst_type_1out_2in == HT) begin
         e_upd = 0; e_rst = 4'b0001; new_halt = 1;
      end
      e_fwd = {fwd_model(used_RmRnRd_1out[2], num_Rm_1out),
               fwd_model(used_RmRnRd_1out[1], num_Rn_1out),
               fwd_model(used_RmRnRd_1out[0], num_Rd_1out)};
      if (chk) begin
         check_val({tag, "_ctl"}, 16'({update_1in, rst_p, pc_load, halted}),
                   16'({e_upd, e_rst, e_pc, e_halt}));
         check_val({tag, "_fwd"}, 16'({fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel}), 16'(e_fwd));
      end
      $display("cyc %0d %s rst=%b br=%b luh=%b upd=%b rst_p=%b pc=%b hlt=%b sel=%h",
               cyc, tag, rst, do_delayed_B_4out, luh, update_1in, rst_p, pc_load, halted,
               {fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel});
      if (rst) begin
         flush_end = 0; halt_pending = 0;
      end else begin
         if (new_flush) flush_end = cyc + FC;
         if (new_halt) begin halt_pending = 1; halt_done = cyc + 4; end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      cycle("reset", 0);
      cycle("reset", 0);
      rst = 0;
      cycle("post_rst", 1);

      write_2out = 1; writenum_2out = 3; num_Rm_1out = 3; used_RmRnRd_1out = 3'b100;
      cycle("fwd01", 1);
      writenum_2out = 4; write_3out = 1; writenum_3out = 3;
      cycle("fwd10", 1);

      clear_inputs();
      loads_2out = 1; write_2out = 1; writenum_2out = 2; num_Rn_1out = 2;
      used_RmRnRd_1out = 3'b010;
      cycle("luh", 1);
      loads_2out = 0; write_2out = 0; write_3out = 1; writenum_3out = 2;
      cycle("luh_next", 1);

      clear_inputs();
      do_delayed_B_4out = 1;
      cycle("br", 1);
      do_delayed_B_4out = 0;
      for (int i = 0; i < 3; i++) cycle("br_flush", 1);

      loads_2out = 1; write_2out = 1; writenum_2out = 5; num_Rd_1out = 5;
      used_RmRnRd_1out = 3'b001; do_delayed_B_4out = 1;
      cycle("luh_br", 1);
      clear_inputs();
      for (int i = 0; i < 3; i++) cycle("luh_br_flush", 1);

      inst_type_1out_2in = HT;
      cycle("halt", 1);
      inst_type_1out_2in = 0;
      for (int i = 0; i < 5; i++) cycle("drain", 1);
      rst = 1;
      cycle("rst_halted", 1);
      rst = 0;
      cycle("after_rst", 1);

      for (int n = 0; n < 1500; n++) begin
         rst                = ($urandom_range(0, 63) == 0) ||
                              (halt_pending && cyc >= halt_done + 5);
         num_Rm_1out        = 3'($urandom_range(0, 3));
         num_Rn_1out        = 3'($urandom_range(0, 3));
         num_Rd_1out        = 3'($urandom_range(0, 3));
         used_RmRnRd_1out   = 3'($urandom);
         writenum_2out      = 3'($urandom_range(0, 3));
         writenum_3out      = 3'($urandom_range(0, 3));
         writenum_out       = 3'($urandom_range(0, 3));
         write_2out         = 1'($urandom);
         write_3out         = 1'($urandom);
         write_out          = 1'($urandom);
         loads_2out         = ($urandom_range(0, 2) == 0);
         do_delayed_B_4out  = ($urandom_range(0, 11) == 0);
         inst_type_1out_2in = ($urandom_range(0, 29) == 0) ? HT : 6'($urandom_range(0, 62));
         cycle("rand", 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
